// File: rtl/vga_cmd_engine.sv
// vga_cmd_engine: byte-stream command decoder feeding the pixel generator.
// Optional macro VGA_CMD_TIMEOUT_EN enables the payload-stall timeout.
module vga_cmd_engine #(
    parameter int COLOR_BITS = 4,
    parameter int FONT_AW = 12,
    parameter logic [3*COLOR_BITS-1:0] FG_RESET = 12'hFF0,
    parameter logic [3*COLOR_BITS-1:0] BG_RESET = 12'h208,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    font_we,
    output logic [FONT_AW-1:0]      font_waddr,
    output logic [7:0]              font_wdata,
    output logic [7:0]              pixreg,
    output logic [3*COLOR_BITS-1:0] fg_color,
    output logic [3*COLOR_BITS-1:0] bg_color,
    output logic                    busy,
    output logic                    err_cmd
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FONT  = 2'd1;
    localparam logic [1:0] S_PIX   = 2'd2;
    localparam logic [1:0] S_COLOR = 2'd3;

    localparam logic [FONT_AW:0] FONT_LAST = {1'b0, {FONT_AW{1'b1}}};

    logic [1:0]            state;
    logic [FONT_AW:0]      fcnt;
    logic [1:0]            cidx;
    logic                  ctgt;
    logic [COLOR_BITS-1:0] r_stg;
    logic [COLOR_BITS-1:0] g_stg;
    logic [COLOR_BITS-1:0] chan;
    logic                  accept;
    logic                  timeout;

    // Ready is held low only while reset is asserted.
    assign in_ready = ~rst;
    assign accept   = in_valid & in_ready;
    assign busy     = (state != S_IDLE);
    assign chan     = in_data[7 -: COLOR_BITS];

`ifdef VGA_CMD_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);

    logic [SW-1:0] stall;

    assign timeout = busy && !accept && (stall == STALL_LAST);

    // Count idle cycles inside a payload; any accepted byte restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall <= '0;
        else if (!busy || accept || timeout)
            stall <= '0;
        else
            stall <= stall + 1'b1;
    end
`else
    logic timeout_unused;

    assign timeout        = 1'b0;
    assign timeout_unused = (TIMEOUT_CYCLES > 1);
`endif

    // Command FSM, payload counters, staging and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            fcnt       <= '0;
            cidx       <= '0;
            ctgt       <= 1'b0;
            r_stg      <= '0;
            g_stg      <= '0;
            font_we    <= 1'b0;
            font_waddr <= '0;
            font_wdata <= '0;
            pixreg     <= '0;
            fg_color   <= FG_RESET;
            bg_color   <= BG_RESET;
            err_cmd    <= 1'b0;
        end else begin
            font_we <= 1'b0;
            if (timeout) begin
                state   <= S_IDLE;
                err_cmd <= 1'b1;
            end else if (accept) begin
                unique case (1'b1)
                    (state == S_IDLE): begin
                        fcnt <= '0;
                        cidx <= '0;
                        case (in_data)
                            8'h00: ;
                            8'h80: state <= S_FONT;
                            8'h81: state <= S_PIX;
                            8'h82: begin
                                state <= S_COLOR;
                                ctgt  <= 1'b0;
                            end
                            8'h83: begin
                                state <= S_COLOR;
                                ctgt  <= 1'b1;
                            end
                            default: err_cmd <= 1'b1;
                        endcase
                    end
                    (state == S_FONT): begin
                        font_we    <= 1'b1;
                        font_waddr <= fcnt[FONT_AW-1:0];
                        font_wdata <= in_data;
                        fcnt       <= fcnt + 1'b1;
                        if (fcnt == FONT_LAST)
                            state <= S_IDLE;
                    end
                    (state == S_PIX): begin
                        pixreg <= in_data;
                        state  <= S_IDLE;
                    end
                    (state == S_COLOR): begin
                        cidx <= cidx + 1'b1;
                        if (cidx == 2'd0)
                            r_stg <= chan;
                        else if (cidx == 2'd1)
                            g_stg <= chan;
                        else begin
                            if (ctgt)
                                bg_color <= {r_stg, g_stg, chan};
                            else
                                fg_color <= {r_stg, g_stg, chan};
                            state <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_cmd_engine.sv
// tb_vga_cmd_engine: directed bench for vga_cmd_engine.
// Uses FONT_AW=4 and TIMEOUT_CYCLES=8; honours VGA_CMD_TIMEOUT_EN.
module tb_vga_cmd_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        font_we;
    logic [3:0]  font_waddr;
    logic [7:0]  font_wdata;
    logic [7:0]  pixreg;
    logic [11:0] fg_color;
    logic [11:0] bg_color;
    logic        busy;
    logic        err_cmd;

    int checks = 0;
    int failures = 0;

    vga_cmd_engine #(
        .COLOR_BITS(4),
        .FONT_AW(4),
        .FG_RESET(12'hFF0),
        .BG_RESET(12'h208),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .font_we(font_we),
        .font_waddr(font_waddr),
        .font_wdata(font_wdata),
        .pixreg(pixreg),
        .fg_color(fg_color),
        .bg_color(bg_color),
        .busy(busy),
        .err_cmd(err_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'h80;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready_rel", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_fg", fg_color, 12'hFF0);
        chk("rst_bg", bg_color, 12'h208);
        chk("rst_pix", pixreg, 0);
        chk("rst_we", font_we, 0);
        chk("rst_err", err_cmd, 0);

        // T2: back-to-back PIXDATA
        send(8'h81);
        chk("t2_busy", busy, 1);
        chk("t2_pix_hold", pixreg, 0);
        send(8'hA5);
        chk("t2_pix_a5", pixreg, 8'hA5);
        chk("t2_idle", busy, 0);
        send(8'h81);
        chk("t2_rdy", in_ready, 1);
        send(8'h3C);
        chk("t2_pix_3c", pixreg, 8'h3C);
        chk("t2_rdy2", in_ready, 1);
        idle(1);

        // T3: LOAD_FONT with a gap after byte 5
        send(8'h80);
        chk("t3_busy", busy, 1);
        chk("t3_we0", font_we, 0);
        for (int k = 0; k < 16; k++) begin
            send(8'h10 + 8'(k));
            chk("t3_we", font_we, 1);
            chk("t3_addr", font_waddr, k);
            chk("t3_data", font_wdata, 8'h10 + 8'(k));
            if (k == 5) begin
                for (int g = 0; g < 3; g++) begin
                    idle(1);
                    chk("t3_gap_we", font_we, 0);
                    chk("t3_gap_busy", busy, 1);
                end
            end
        end
        chk("t3_done", busy, 0);
        idle(1);
        chk("t3_no_extra", font_we, 0);

        // T4: SET_FG, then SET_BG carrying 0x83 as data
        send(8'h82);
        send(8'h9F);
        chk("t4_fg_b1", fg_color, 12'hFF0);
        send(8'h4E);
        chk("t4_fg_b2", fg_color, 12'hFF0);
        send(8'hC1);
        chk("t4_fg", fg_color, 12'h94C);
        chk("t4_idle", busy, 0);
        send(8'h83);
        send(8'h83);
        chk("t4_data83", busy, 1);
        chk("t4_err0", err_cmd, 0);
        send(8'h20);
        send(8'hF0);
        chk("t4_bg", bg_color, 12'h82F);
        chk("t4_fg_keep", fg_color, 12'h94C);
        chk("t4_idle2", busy, 0);

        // T5: unknown opcode is sticky
        send(8'h7E);
        chk("t5_err", err_cmd, 1);
        chk("t5_idle", busy, 0);
        send(8'h81);
        send(8'h01);
        chk("t5_pix", pixreg, 8'h01);
        chk("t5_sticky", err_cmd, 1);
        idle(1);

        // T1: reset mid-FONT and mid-colour state
        send(8'h80);
        for (int k = 0; k < 10; k++) send(8'hE0 + 8'(k));
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t1_we", font_we, 0);
        chk("t1_busy", busy, 0);
        chk("t1_fg", fg_color, 12'hFF0);
        chk("t1_bg", bg_color, 12'h208);
        chk("t1_err", err_cmd, 0);
        chk("t1_rdy", in_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(8'h81);
        send(8'h55);
        chk("t1_pix", pixreg, 8'h55);
        send(8'h80);
        send(8'hAB);
        chk("t1_addr0", font_waddr, 0);
        chk("t1_data", font_wdata, 8'hAB);
        for (int k = 1; k < 16; k++) send(8'(k));
        chk("t1_font_done", busy, 0);

        // T6: payload stall
        send(8'h82);
        send(8'h11);
        idle(7);
        chk("t6_busy7", busy, 1);
        idle(1);
`ifdef VGA_CMD_TIMEOUT_EN
        chk("t6_busy", busy, 0);
        chk("t6_err", err_cmd, 1);
        chk("t6_fg", fg_color, 12'hFF0);
        chk("t6_pix", pixreg, 8'h55);
        send(8'h81);
        send(8'h77);
        chk("t6_after", pixreg, 8'h77);
`else
        chk("t6_busy", busy, 1);
        idle(40);
        chk("t6_busy_long", busy, 1);
        chk("t6_err", err_cmd, 0);
        send(8'h22);
        send(8'h33);
        chk("t6_fg", fg_color, 12'h123);
        chk("t6_idle", busy, 0);
`endif
        in_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
